// File: rtl/ptw_responder_pkg.sv
// Shared definitions for the page-table-walk responder: FSM states, PTE
// bit positions, cache geometry and the bus-wait default.
package ptw_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } ptw_state_e;

  // Valid bit of a RISC-V PTE.
  localparam int unsigned PTE_V = 0;

  // Default bus-wait limit in cycles (8-bit counter, so 1..255).
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Cache geometry: direct mapped, indexed by word address bits [3:2],
  // tagged with the remaining upper bits.
  localparam int unsigned CACHE_ENTRIES = 4;
  localparam int unsigned IDX_LSB       = 2;
  localparam int unsigned IDX_MSB       = 3;
  localparam int unsigned TAG_LSB       = 4;
  localparam int unsigned TAG_MSB       = 31;
  localparam int unsigned IDX_W         = IDX_MSB - IDX_LSB + 1;
  localparam int unsigned TAG_W         = TAG_MSB - TAG_LSB + 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } pte_entry_t;

  // PTE returned on bus error or timeout: all zero, in particular V clear,
  // so the MMU raises a page fault.
  function automatic logic [31:0] fault_pte();
    logic [31:0] pte;
    pte        = '0;
    pte[PTE_V] = 1'b0;
    return pte;
  endfunction

endpackage

// File: rtl/ptw_pte_cache.sv
// Four-entry direct-mapped PTE cache: combinational lookup, single-cycle
// fill, and a flush that drops every valid bit at once.
module ptw_pte_cache
  import ptw_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] lookup_idx,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_hit,
  output logic [31:0]      lookup_data,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [31:0]      fill_data,
  input  logic             flush
);

  logic [CACHE_ENTRIES-1:0] valid_q;
  pte_entry_t               entry_q [CACHE_ENTRIES];

  // Valid bits: flush wins over a fill in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is always assigned with <= so every flop
    // samples the pre-edge value of its neighbours.
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data storage is only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the valid bits
    // alone decide whether an entry may be used.
    if (fill_en) begin
      entry_q[fill_idx] <= '{tag: fill_tag, data: fill_data};
    end
  end

  assign lookup_hit  = valid_q[lookup_idx] && (entry_q[lookup_idx].tag == lookup_tag);
  assign lookup_data = entry_q[lookup_idx].data;

endmodule

// File: rtl/ptw_responder.sv
// Page-table-walk responder: answers MMU PTE reads from a small cache or
// through a Wishbone classic read, with error/timeout turned into V=0.
module ptw_responder
  import ptw_responder_pkg::*;
#(
  parameter int unsigned CACHE_EN = 1,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ptw_req,
  input  logic [31:0] ptw_addr,
  output logic [31:0] ptw_data,
  output logic        ptw_ack,
  input  logic        pte_flush,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  // Counter value seen in the last permitted bus cycle; the completing
  // edge then brings the counter to TIMEOUT.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  ptw_state_e  state;
  logic [31:2] addr_q;
  logic [7:0]  tmo_cnt;
  logic        flush_seen;

  logic        cache_hit;
  logic [31:0] cache_data;
  logic        lookup_hit;
  logic        fill_en;
  logic        bus_done;
  logic        tmo_done;
  logic        unused_addr_bits;

  // Byte offset of a PTE address never reaches the bus or the cache.
  assign unused_addr_bits = ^ptw_addr[1:0];

  // A flush in the request cycle forces a miss even if the entry matched.
  assign lookup_hit = (CACHE_EN != 0) && cache_hit && !pte_flush;

  // Ack and err take precedence; the timeout only ends a silent cycle.
  assign tmo_done = !wb_ack_i && !wb_err_i && (tmo_cnt == TMO_LAST);
  assign bus_done = wb_ack_i || wb_err_i || tmo_done;

  // Only a clean ack with no flush anywhere in the bus cycle is cached.
  assign fill_en = (CACHE_EN != 0) && (state == BUS) && wb_ack_i && !wb_err_i &&
                   !flush_seen && !pte_flush;

  ptw_pte_cache u_cache (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_idx  (ptw_addr[IDX_MSB:IDX_LSB]),
    .lookup_tag  (ptw_addr[TAG_MSB:TAG_LSB]),
    .lookup_hit  (cache_hit),
    .lookup_data (cache_data),
    .fill_en     (fill_en),
    .fill_idx    (addr_q[IDX_MSB:IDX_LSB]),
    .fill_tag    (addr_q[TAG_MSB:TAG_LSB]),
    .fill_data   (wb_dat_i),
    .flush       (pte_flush)
  );

  // Walk FSM with registered MMU and Wishbone outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      tmo_cnt    <= '0;
      flush_seen <= 1'b0;
      ptw_ack    <= 1'b0;
      ptw_data   <= '0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_adr_o   <= '0;
      wb_sel_o   <= '0;
      wb_we_o    <= 1'b0;
    end else begin
      ptw_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ptw_req) begin
            addr_q <= ptw_addr[31:2];
            if (lookup_hit) begin
              state    <= RESP;
              ptw_ack  <= 1'b1;
              ptw_data <= cache_data;
            end else begin
              state      <= BUS;
              tmo_cnt    <= '0;
              flush_seen <= 1'b0;
              wb_cyc_o   <= 1'b1;
              wb_stb_o   <= 1'b1;
              wb_adr_o   <= {ptw_addr[31:2], 2'b00};
              wb_sel_o   <= 4'hF;
              wb_we_o    <= 1'b0;
            end
          end
        end
        BUS: begin
          if (pte_flush) begin
            flush_seen <= 1'b1;
          end
          if (!wb_ack_i && !wb_err_i) begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
          if (bus_done) begin
            state    <= RESP;
            ptw_ack  <= 1'b1;
            ptw_data <= (wb_ack_i && !wb_err_i) ? wb_dat_i : fault_pte();
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_sel_o <= '0;
          end
        end
        RESP: begin
          // The request still held here is the one being acknowledged.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ptw_responder.sv
// Directed bench for ptw_responder: misses, hits, bus error, timeout,
// flush interaction, back-to-back walks and reset during a bus cycle.
module tb_ptw_responder;
  import ptw_responder_pkg::*;

  typedef enum int {R_ACK, R_ERR, R_BOTH, R_NONE} resp_e;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ptw_req;
  logic [31:0] ptw_addr;
  logic [31:0] ptw_data;
  logic        ptw_ack;
  logic        pte_flush;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  int n_chk = 0;
  int n_err = 0;

  ptw_responder #(.CACHE_EN(1), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ptw_req   (ptw_req),
    .ptw_addr  (ptw_addr),
    .ptw_data  (ptw_data),
    .ptw_ack   (ptw_ack),
    .pte_flush (pte_flush),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_adr_o  (wb_adr_o),
    .wb_sel_o  (wb_sel_o),
    .wb_we_o   (wb_we_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One MMU request plus a scripted Wishbone slave. The slave answers in
  // bus cycle wait_n+1; pte_flush can be pulsed in the request cycle or
  // in a chosen bus cycle. Returns with ptw_req still high in the ack cycle.
  task automatic walk(input logic [31:0] addr, input int wait_n, input resp_e kind,
                      input logic [31:0] rdata, input int flush_bc, input logic flush_c0,
                      output int lat, output int bus_n, output logic [31:0] adr_seen,
                      output logic [31:0] data);
    lat       = -1;
    bus_n     = 0;
    adr_seen  = '0;
    data      = 'x;
    ptw_req   = 1'b1;
    ptw_addr  = addr;
    pte_flush = flush_c0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      step();
      wb_ack_i  = 1'b0;
      wb_err_i  = 1'b0;
      wb_dat_i  = '0;
      pte_flush = 1'b0;
      if (ptw_ack) begin
        lat  = c;
        data = ptw_data;
      end else if (wb_cyc_o) begin
        bus_n++;
        if (bus_n == 1) adr_seen = wb_adr_o;
        if (bus_n == flush_bc) pte_flush = 1'b1;
        if (bus_n == wait_n + 1) begin
          case (kind)
            R_ACK:  begin wb_ack_i = 1'b1; wb_dat_i = rdata; end
            R_ERR:  begin wb_err_i = 1'b1; wb_dat_i = rdata; end
            R_BOTH: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = rdata; end
            default: ;
          endcase
        end
      end
    end
  endtask

  // Cycle after the ack: pulse is over, no bus cycle started by the held
  // request, and the response is still on ptw_data.
  task automatic after_ack(input string tag, input logic [31:0] exp_data);
    step();
    check({tag, "_ack_low"}, {31'b0, ptw_ack}, 32'd0);
    check({tag, "_no_cyc"}, {31'b0, wb_cyc_o}, 32'd0);
    check({tag, "_data_hold"}, ptw_data, exp_data);
  endtask

  int          lat;
  int          bus_n;
  logic [31:0] adr;
  logic [31:0] d;

  initial begin
    rst_n     = 1'b0;
    ptw_req   = 1'b0;
    ptw_addr  = '0;
    pte_flush = 1'b0;
    wb_dat_i  = '0;
    wb_ack_i  = 1'b0;
    wb_err_i  = 1'b0;
    step();
    step();
    check("rst_ack",  {31'b0, ptw_ack}, 32'd0);
    check("rst_data", ptw_data, 32'd0);
    check("rst_cyc",  {31'b0, wb_cyc_o}, 32'd0);
    check("rst_stb",  {31'b0, wb_stb_o}, 32'd0);
    check("rst_adr",  wb_adr_o, 32'd0);
    check("rst_sel",  {28'b0, wb_sel_o}, 32'd0);
    check("rst_we",   {31'b0, wb_we_o}, 32'd0);
    rst_n = 1'b1;
    step();

    // Miss with three wait cycles.
    walk(32'h8000_1004, 3, R_ACK, 32'h2000_0401, -1, 1'b0, lat, bus_n, adr, d);
    check("miss_lat",  lat, 32'd5);
    check("miss_adr",  adr, 32'h8000_1004);
    check("miss_bus",  bus_n, 32'd4);
    check("miss_data", d, 32'h2000_0401);
    after_ack("miss", 32'h2000_0401);
    ptw_req = 1'b0;
    step();

    // Same address hits.
    walk(32'h8000_1004, 0, R_ACK, 32'hDEAD_0000, -1, 1'b0, lat, bus_n, adr, d);
    check("hit_lat",  lat, 32'd1);
    check("hit_bus",  bus_n, 32'd0);
    check("hit_data", d, 32'h2000_0401);
    after_ack("hit", 32'h2000_0401);
    ptw_req = 1'b0;

    // Bus error on the first bus cycle; repeat must miss.
    walk(32'h8000_2008, 0, R_ERR, 32'hDEAD_BEEF, -1, 1'b0, lat, bus_n, adr, d);
    check("err_lat",  lat, 32'd2);
    check("err_data", d, 32'd0);
    check("err_v",    {31'b0, d[PTE_V]}, 32'd0);
    after_ack("err", 32'd0);
    ptw_req = 1'b0;
    walk(32'h8000_2008, 0, R_ACK, 32'h1111_2223, -1, 1'b0, lat, bus_n, adr, d);
    check("err_rep_bus",  bus_n, 32'd1);
    check("err_rep_data", d, 32'h1111_2223);
    after_ack("err_rep", 32'h1111_2223);
    ptw_req = 1'b0;

    // Ack and err together: err wins, nothing cached.
    walk(32'h8000_300C, 1, R_BOTH, 32'h3333_3333, -1, 1'b0, lat, bus_n, adr, d);
    check("both_lat",  lat, 32'd3);
    check("both_data", d, 32'd0);
    after_ack("both", 32'd0);
    ptw_req = 1'b0;
    walk(32'h8000_300C, 0, R_ACK, 32'h4444_0001, -1, 1'b0, lat, bus_n, adr, d);
    check("both_rep_bus",  bus_n, 32'd1);
    check("both_rep_data", d, 32'h4444_0001);
    after_ack("both_rep", 32'h4444_0001);
    ptw_req = 1'b0;

    // Timeout after four silent bus cycles, twice.
    walk(32'h8000_4000, 99, R_NONE, 32'd0, -1, 1'b0, lat, bus_n, adr, d);
    check("tmo_lat",  lat, 32'd5);
    check("tmo_bus",  bus_n, 32'd4);
    check("tmo_data", d, 32'd0);
    after_ack("tmo", 32'd0);
    ptw_req = 1'b0;
    walk(32'h8000_4000, 99, R_NONE, 32'd0, -1, 1'b0, lat, bus_n, adr, d);
    check("tmo_rep_bus", bus_n, 32'd4);
    after_ack("tmo_rep", 32'd0);
    ptw_req = 1'b0;

    // Flush during the fill's bus cycle: data returned, entry not kept.
    walk(32'h8000_5010, 2, R_ACK, 32'h5555_0001, 2, 1'b0, lat, bus_n, adr, d);
    check("fl_bus_lat",  lat, 32'd4);
    check("fl_bus_data", d, 32'h5555_0001);
    after_ack("fl_bus", 32'h5555_0001);
    ptw_req = 1'b0;
    walk(32'h8000_5010, 0, R_ACK, 32'h5555_0003, -1, 1'b0, lat, bus_n, adr, d);
    check("fl_bus_rep_bus",  bus_n, 32'd1);
    check("fl_bus_rep_data", d, 32'h5555_0003);
    after_ack("fl_bus_rep", 32'h5555_0003);
    ptw_req = 1'b0;

    // Flush in the cycle that would hit: forced miss, other entries gone too.
    walk(32'h8000_5010, 0, R_ACK, 32'h6666_0001, -1, 1'b1, lat, bus_n, adr, d);
    check("fl_hit_bus",  bus_n, 32'd1);
    check("fl_hit_data", d, 32'h6666_0001);
    after_ack("fl_hit", 32'h6666_0001);
    ptw_req = 1'b0;
    walk(32'h8000_1004, 0, R_ACK, 32'h2000_0401, -1, 1'b0, lat, bus_n, adr, d);
    check("fl_all_bus", bus_n, 32'd1);
    after_ack("fl_all", 32'h2000_0401);
    ptw_req = 1'b0;

    // Back-to-back L1 then L2 the following cycle.
    walk(32'h8000_6000, 1, R_ACK, 32'h2000_1801, -1, 1'b0, lat, bus_n, adr, d);
    check("l1_lat",  lat, 32'd3);
    check("l1_data", d, 32'h2000_1801);
    after_ack("l1", 32'h2000_1801);
    walk(32'h8000_7008, 0, R_ACK, 32'h2000_00CF, -1, 1'b0, lat, bus_n, adr, d);
    check("l2_lat",  lat, 32'd2);
    check("l2_adr",  adr, 32'h8000_7008);
    check("l2_data", d, 32'h2000_00CF);
    after_ack("l2", 32'h2000_00CF);
    ptw_req = 1'b0;

    // Reset two cycles into a bus cycle.
    ptw_req  = 1'b1;
    ptw_addr = 32'h8000_8000;
    step();
    check("rb_cyc", {31'b0, wb_cyc_o}, 32'd1);
    check("rb_sel", {28'b0, wb_sel_o}, 32'hF);
    check("rb_we",  {31'b0, wb_we_o}, 32'd0);
    step();
    rst_n   = 1'b0;
    ptw_req = 1'b0;
    #1;
    check("rb_cyc_drop", {31'b0, wb_cyc_o}, 32'd0);
    check("rb_stb_drop", {31'b0, wb_stb_o}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rb_no_ack", {31'b0, ptw_ack | wb_cyc_o}, 32'd0);
    end
    walk(32'h8000_1004, 0, R_ACK, 32'h2000_0402, -1, 1'b0, lat, bus_n, adr, d);
    check("rb_idle_lat", lat, 32'd2);
    check("rb_idle_bus", bus_n, 32'd1);
    check("rb_idle_data", d, 32'h2000_0402);
    after_ack("rb_idle", 32'h2000_0402);
    ptw_req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
